multi_byte_lookahead_add_sequencer: RTL and testbench
=====================================================

// Module: multi_byte_lookahead_add_sequencer
// PURPOSE
//   Sequencer directly upstream of the 8-bit look-ahead carry adder. Adds or subtracts two
//   NUM_BYTES-wide operands one byte per clock through a single external 8-bit adder.
//   Drives the adder's operand, carry and enable inputs, captures its sum and carry each
//   cycle, and chains the carry from byte to byte. Returns the full-width result with a
//   Done pulse, carry out and signed overflow.
// PARAMETERS
//   NUM_BYTES   4   operand width in bytes (>=1); operand width W = 8*NUM_BYTES
// PORTS
//   Clock_In          in   1   single clock, rising edge
//   Reset_In          in   1   synchronous, active-high reset
//   Start_In          in   1   request; accepted only in IDLE or DONE
//   Subtract_In       in   1   0: A+B+Cin; 1: A+~B+Cin (Cin=1 gives A-B); sampled with Start
//   Data_A_In         in   W   operand A, sampled on accepted Start
//   Data_B_In         in   W   operand B, sampled on accepted Start
//   Carry_In          in   1   initial carry, sampled on accepted Start
//   Busy_Out          out  1   high in RUN
//   Done_Out          out  1   one-cycle pulse, result valid
//   Sum_Out           out  W   result; held from Done until the next accepted Start
//   Carry_Out         out  1   carry out of the MSB byte
//   Overflow_Out      out  1   signed two's-complement overflow
//   Adder_Enable_Out  out  1   to adder Enable_In; high only in RUN
//   Adder_A_Out       out  8   to adder Data_A_In: current byte of latched A
//   Adder_B_Out       out  8   to adder Data_B_In: current byte of latched B (pre-inverted if sub)
//   Adder_Carry_Out   out  1   to adder Carry_In: chained carry register
//   Adder_Sum_In      in   8   from adder Sum_Out (combinational, same cycle)
//   Adder_Carry_In    in   1   from adder Carry_Out (combinational, same cycle)
// BEHAVIOUR
//   Reset: state=IDLE, byte index=0, all outputs 0 (incl. Sum_Out, Adder_* outputs). Reset
//     in mid-operation aborts the operation. No Done is issued, and the partial sum is cleared.
//   FSM states: IDLE, RUN, DONE.
//     IDLE --Start--> RUN; DONE --Start--> RUN (back-to-back); DONE --no Start--> IDLE;
//     RUN --index==NUM_BYTES-1--> DONE.
//   Accept (Start in IDLE/DONE): latch A, B_eff = Subtract ? ~B : B, carry_reg = Carry_In,
//     index = 0. Start while in RUN is ignored and has no side effects.
//   RUN, each cycle: Adder_A/B_Out = byte[index] of A/B_eff; Adder_Carry_Out = carry_reg;
//     sum byte[index] <= Adder_Sum_In; carry_reg <= Adder_Carry_In; index++.
//   Adder_Sum_In/Adder_Carry_In are sampled only when Adder_Enable_Out=1 (adder tri-states
//     its outputs otherwise); Adder_A/B/Carry_Out are driven 0 outside RUN.
//   Latency: Start accepted at edge T -> RUN cycles T+1..T+NUM_BYTES -> Done_Out high in the
//     cycle after edge T+NUM_BYTES; exactly one Done per accepted Start.
//   Sum_Out, Carry_Out and Overflow_Out update only on the transition into DONE. They hold
//     through IDLE, and through RUN of a following operation, until that operation's DONE.
//   Carry_Out = final carry_reg (for subtraction, 1 = no borrow).
//   Overflow_Out = (A[W-1] == B_eff[W-1]) && (Sum[W-1] != A[W-1]).
//   Widths: all arithmetic is modulo 2^W. Wrap-around is reported only via Carry_Out.
//   NUM_BYTES=1: a single RUN cycle; the index counter never increments past 0.
// TESTING
//   T1 NUM_BYTES=4: A=FFFFFFFF,B=00000001,Cin=0,add -> Sum=00000000,Carry=1,Ovf=0,Done at T+5.
//   T2 sub: A=00000000,B=00000001,Cin=1 -> Sum=FFFFFFFF,Carry=0,Ovf=0.
//   T3 add: A=7FFFFFFF,B=00000001,Cin=0 -> Sum=80000000,Carry=0,Ovf=1; A=80000000 + B=80000000
//      -> Sum=0,Carry=1,Ovf=1.
//   T4 Start re-asserted with new operands during RUN -> ignored; one Done; result from first
//      operands. Start held in DONE -> next op starts, Done pulses exactly NUM_BYTES+1 apart.
//   T5 Reset_In high at RUN byte 2 -> next cycle IDLE, Busy=0, Sum_Out=0, no Done pulse.
//   T6 NUM_BYTES=1: A=FF,B=01,Cin=1 -> Sum=01,Carry=1, Done one cycle after RUN; Adder_Enable
//      high for exactly one cycle per op.

Source files
------------

// File: rtl/multi_byte_lookahead_add_sequencer.sv
//------------------------------------------------------------------------------
// multi_byte_lookahead_add_sequencer: byte-serial add/subtract via external 8-bit adder
// Rev 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module multi_byte_lookahead_add_sequencer #(
  parameter int NUM_BYTES = 4
) (
  input  logic                     Clock_In,
  input  logic                     Reset_In,
  input  logic                     Start_In,
  input  logic                     Subtract_In,
  input  logic [8*NUM_BYTES-1:0]   Data_A_In,
  input  logic [8*NUM_BYTES-1:0]   Data_B_In,
  input  logic                     Carry_In,
  output logic                     Busy_Out,
  output logic                     Done_Out,
  output logic [8*NUM_BYTES-1:0]   Sum_Out,
  output logic                     Carry_Out,
  output logic                     Overflow_Out,
  output logic                     Adder_Enable_Out,
  output logic [7:0]               Adder_A_Out,
  output logic [7:0]               Adder_B_Out,
  output logic                     Adder_Carry_Out,
  input  logic [7:0]               Adder_Sum_In,
  input  logic                     Adder_Carry_In
);

  localparam int W     = 8 * NUM_BYTES;
  localparam int IDX_W = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);

  logic [1:0]       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [W-1:0]     a_q, a_d;
  logic [W-1:0]     b_q, b_d;
  logic [W-1:0]     acc_q, acc_d;
  logic [W-1:0]     sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic             run;
  logic             accept;
  logic [7:0]       byte_a;
  logic [7:0]       byte_b;

  always_comb begin
    run    = (state_q == S_RUN);
    accept = Start_In && ((state_q == S_IDLE) || (state_q == S_DONE));

    byte_a = 8'h00;
    byte_b = 8'h00;
    for (int i = 0; i < NUM_BYTES; i++) begin
      if (idx_q == IDX_W'(i)) begin
        byte_a = a_q[8*i +: 8];
        byte_b = b_q[8*i +: 8];
      end
    end

    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    case (state_q)
      S_IDLE: begin
        if (accept) state_d = S_RUN;
      end
      S_RUN: begin
        for (int i = 0; i < NUM_BYTES; i++) begin
          if (idx_q == IDX_W'(i)) acc_d[8*i +: 8] = Adder_Sum_In;
        end
        carry_d = Adder_Carry_In;
        if (idx_q == LAST_IDX) begin
          // Result registers change only here, so Sum_Out holds across later RUN phases
          state_d = S_DONE;
          idx_d   = '0;
          sum_d   = acc_d;
          cout_d  = Adder_Carry_In;
          ovf_d   = (a_q[W-1] == b_q[W-1]) && (Adder_Sum_In[7] != a_q[W-1]);
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      S_DONE: begin
        state_d = accept ? S_RUN : S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (accept) begin
      a_d     = Data_A_In;
      b_d     = Subtract_In ? ~Data_B_In : Data_B_In;
      carry_d = Carry_In;
      idx_d   = '0;
      acc_d   = '0;
    end
  end

  always_ff @(posedge Clock_In) begin
    if (Reset_In) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign Busy_Out         = run;
  assign Done_Out         = (state_q == S_DONE);
  assign Sum_Out          = sum_q;
  assign Carry_Out        = cout_q;
  assign Overflow_Out     = ovf_q;
  assign Adder_Enable_Out = run;
  assign Adder_A_Out      = run ? byte_a : 8'h00;
  assign Adder_B_Out      = run ? byte_b : 8'h00;
  assign Adder_Carry_Out  = run & carry_q;

endmodule

`default_nettype wire

// File: tb/tb_multi_byte_lookahead_add_sequencer.sv
// Scoreboard bench: 4-byte and 1-byte sequencer instances, each with a behavioural 8-bit adder.
`default_nettype none

module tb_multi_byte_lookahead_add_sequencer;

  typedef struct {
    logic [31:0] sum;
    logic        c;
    logic        o;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  exp_t q4[$];
  exp_t q1[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // 4-byte instance
  logic        start4 = 0, sub4 = 0, cin4 = 0;
  logic [31:0] a4 = 0, b4 = 0;
  logic        busy4, done4, cout4, ovf4, en4, adc4, acin4;
  logic [31:0] sum4;
  logic [7:0]  ada4, adb4, adsum4;
  logic [8:0]  t4;

  assign t4     = {1'b0, ada4} + {1'b0, adb4} + {8'b0, adc4};
  assign adsum4 = en4 ? t4[7:0] : 8'h5A;
  assign acin4  = en4 ? t4[8]   : 1'b1;

  multi_byte_lookahead_add_sequencer #(.NUM_BYTES(4)) dut4 (
    .Clock_In(clk), .Reset_In(rst), .Start_In(start4), .Subtract_In(sub4),
    .Data_A_In(a4), .Data_B_In(b4), .Carry_In(cin4),
    .Busy_Out(busy4), .Done_Out(done4), .Sum_Out(sum4), .Carry_Out(cout4),
    .Overflow_Out(ovf4), .Adder_Enable_Out(en4), .Adder_A_Out(ada4),
    .Adder_B_Out(adb4), .Adder_Carry_Out(adc4), .Adder_Sum_In(adsum4),
    .Adder_Carry_In(acin4)
  );

  // 1-byte instance
  logic        start1 = 0, sub1 = 0, cin1 = 0;
  logic [7:0]  a1 = 0, b1 = 0;
  logic        busy1, done1, cout1, ovf1, en1, adc1, acin1;
  logic [7:0]  sum1, ada1, adb1, adsum1;
  logic [8:0]  t1;

  assign t1     = {1'b0, ada1} + {1'b0, adb1} + {8'b0, adc1};
  assign adsum1 = en1 ? t1[7:0] : 8'hA5;
  assign acin1  = en1 ? t1[8]   : 1'b1;

  multi_byte_lookahead_add_sequencer #(.NUM_BYTES(1)) dut1 (
    .Clock_In(clk), .Reset_In(rst), .Start_In(start1), .Subtract_In(sub1),
    .Data_A_In(a1), .Data_B_In(b1), .Carry_In(cin1),
    .Busy_Out(busy1), .Done_Out(done1), .Sum_Out(sum1), .Carry_Out(cout1),
    .Overflow_Out(ovf1), .Adder_Enable_Out(en1), .Adder_A_Out(ada1),
    .Adder_B_Out(adb1), .Adder_Carry_Out(adc1), .Adder_Sum_In(adsum1),
    .Adder_Carry_In(acin1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitors: pop expected result whenever a Done pulse appears
  int en_cnt4 = 0;
  int en_cnt1 = 0;

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      en_cnt4 = 0;
    end else begin
      if (en4) en_cnt4++;
      if (done4) begin
        if (q4.size() == 0) begin
          chk("done4_unexpected", 32'd1, 32'd0);
        end else begin
          e = q4.pop_front();
          chk("sum4", sum4, e.sum);
          chk("carry4", {31'b0, cout4}, {31'b0, e.c});
          chk("ovf4", {31'b0, ovf4}, {31'b0, e.o});
          chk("done4_cycle", cyc, e.cyc);
          chk("enable4_cycles", en_cnt4, 32'd4);
        end
        en_cnt4 = 0;
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      en_cnt1 = 0;
    end else begin
      if (en1) en_cnt1++;
      if (done1) begin
        if (q1.size() == 0) begin
          chk("done1_unexpected", 32'd1, 32'd0);
        end else begin
          e = q1.pop_front();
          chk("sum1", {24'b0, sum1}, e.sum);
          chk("carry1", {31'b0, cout1}, {31'b0, e.c});
          chk("ovf1", {31'b0, ovf1}, {31'b0, e.o});
          chk("done1_cycle", cyc, e.cyc);
          chk("enable1_cycles", en_cnt1, 32'd1);
        end
        en_cnt1 = 0;
      end
    end
  end

  // Called at a negedge while the 4-byte DUT is in IDLE or DONE
  task automatic issue4(input logic [31:0] a, input logic [31:0] b, input logic s,
                        input logic ci, input logic [31:0] es, input logic ec, input logic eo);
    exp_t e;
    a4 = a; b4 = b; sub4 = s; cin4 = ci; start4 = 1'b1;
    e.sum = es; e.c = ec; e.o = eo; e.cyc = cyc + 1 + 4;
    q4.push_back(e);
    @(negedge clk);
    start4 = 1'b0;
  endtask

  task automatic issue1(input logic [7:0] a, input logic [7:0] b, input logic s,
                        input logic ci, input logic [7:0] es, input logic ec, input logic eo);
    exp_t e;
    a1 = a; b1 = b; sub1 = s; cin1 = ci; start1 = 1'b1;
    e.sum = {24'b0, es}; e.c = ec; e.o = eo; e.cyc = cyc + 1 + 1;
    q1.push_back(e);
    @(negedge clk);
    start1 = 1'b0;
  endtask

  task automatic drain(input int limit);
    int k = 0;
    while ((q4.size() != 0 || q1.size() != 0) && k < limit) begin
      @(negedge clk);
      k++;
    end
    chk("drain_timeout", {31'b0, (q4.size() != 0 || q1.size() != 0)}, 32'd0);
    @(negedge clk);
  endtask

  initial begin
    exp_t e;
    int   t0;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_sum4", sum4, 32'h0);
    chk("reset_flags4", {busy4, done4, cout4, ovf4, en4, adc4}, 32'h0);
    chk("reset_adder_ops4", {ada4, adb4}, 32'h0);
    chk("reset_flags1", {sum1, busy1, done1, cout1, ovf1, en1}, 32'h0);

    // Basic add/subtract vectors
    issue4(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0);
    chk("busy4_in_run", {31'b0, busy4}, 32'd1);
    drain(20);
    issue4(32'h00000000, 32'h00000001, 1'b1, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0);
    drain(20);
    issue4(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1);
    drain(20);
    issue4(32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1);
    drain(20);
    issue4(32'h00000005, 32'h00000003, 1'b1, 1'b1, 32'h00000002, 1'b1, 1'b0);
    drain(20);
    issue4(32'h80000000, 32'h00000001, 1'b1, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1);
    drain(20);
    issue4(32'h000000FF, 32'h00000000, 1'b0, 1'b1, 32'h00000100, 1'b0, 1'b0);
    drain(20);

    // Start pulsed during RUN with different operands must be ignored
    issue4(32'h12345678, 32'h11111111, 1'b0, 1'b0, 32'h23456789, 1'b0, 1'b0);
    a4 = 32'h0; b4 = 32'h0; sub4 = 1'b1; cin4 = 1'b1; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    drain(20);

    // Start held through RUN into DONE: back-to-back operations
    t0 = cyc + 1;
    a4 = 32'h00000001; b4 = 32'h00000002; sub4 = 1'b0; cin4 = 1'b0; start4 = 1'b1;
    e.sum = 32'h00000003; e.c = 1'b0; e.o = 1'b0; e.cyc = t0 + 4;
    q4.push_back(e);
    @(negedge clk);
    a4 = 32'h00FF00FF; b4 = 32'h00010001;
    e.sum = 32'h01000100; e.c = 1'b0; e.o = 1'b0; e.cyc = t0 + 5 + 4;
    q4.push_back(e);
    while (cyc < t0 + 5) @(negedge clk);
    start4 = 1'b0;
    chk("busy4_back_to_back", {31'b0, busy4}, 32'd1);
    chk("sum4_held_in_run", sum4, 32'h00000003);
    drain(20);

    // Reset during RUN byte 2 aborts and clears the result
    a4 = 32'hAAAAAAAA; b4 = 32'h11111111; sub4 = 1'b0; cin4 = 1'b0; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy4", {31'b0, busy4}, 32'd0);
    chk("abort_sum4", sum4, 32'h0);
    chk("abort_done_carry4", {30'b0, done4, cout4}, 32'd0);
    repeat (8) @(negedge clk);

    // Single-byte instance
    issue1(8'hFF, 8'h01, 1'b0, 1'b1, 8'h01, 1'b1, 1'b0);
    drain(10);
    issue1(8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
    drain(10);
    issue1(8'h03, 8'h05, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0);
    drain(10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule

`default_nettype wire
